// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the MEM stage, the loader/debug requester and the data memory.
// The arbiter connects through the slave modport; the environment uses master.
interface dmem_port_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          p_req;
  logic          p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  logic [DW-1:0] p_rdata;
  logic          p_stall;

  logic          l_req;
  logic          l_we;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic          l_ack;
  logic [DW-1:0] l_rdata;

  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport master (
    output p_req, p_we, p_addr, p_wdata, l_req, l_we, l_addr, l_wdata, m_rdata,
    input  p_rdata, p_stall, l_ack, l_rdata, m_we, m_addr, m_wdata
  );

  modport slave (
    input  p_req, p_we, p_addr, p_wdata, l_req, l_we, l_addr, l_wdata, m_rdata,
    output p_rdata, p_stall, l_ack, l_rdata, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: pipeline priority, loader served via LGNT/LACK handshake.
// Optional starvation guard (wait_cnt vs MAX_WAIT) enabled by macro DMEM_ARB_STARVE_EN.
module dmem_port_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
`ifdef DMEM_ARB_STARVE_EN
  ,
  parameter int MAX_WAIT = 4
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  dmem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    LGNT = 2'd1,
    LACK = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          l_win;
  logic          lwe_q;
  logic [AW-1:0] laddr_q;
  logic [DW-1:0] lwdata_q;
  logic [DW-1:0] lrdata_q;

  logic          m_we_d;
  logic [AW-1:0] m_addr_d;
  logic [DW-1:0] m_wdata_d;
  logic          p_stall_d;
  logic          l_ack_d;

`ifdef DMEM_ARB_STARVE_EN
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait_q, wait_d;

  assign l_win = bus.l_req & (~bus.p_req | (wait_q == WAIT_MAX));

  always_comb begin
    wait_d = wait_q;
    if (state_q == ARB) begin
      if (l_win) begin
        wait_d = '0;
      end else if (bus.l_req && bus.p_req && (wait_q != WAIT_MAX)) begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign l_win = bus.l_req & ~bus.p_req;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // LACK always returns to ARB so the pipeline gets at least one cycle in three.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (l_win) state_d = LGNT;
      LGNT:    state_d = LACK;
      LACK:    state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lwe_q    <= 1'b0;
      laddr_q  <= '0;
      lwdata_q <= '0;
      lrdata_q <= '0;
    end else begin
      if ((state_q == ARB) && l_win) begin
        lwe_q    <= bus.l_we;
        laddr_q  <= bus.l_addr;
        lwdata_q <= bus.l_wdata;
      end
      if ((state_q == LGNT) && !lwe_q) begin
        lrdata_q <= bus.m_rdata;
      end
    end
  end

  always_comb begin
    m_we_d    = bus.p_req & bus.p_we;
    m_addr_d  = bus.p_addr;
    m_wdata_d = bus.p_wdata;
    p_stall_d = 1'b0;
    l_ack_d   = 1'b0;
    case (state_q)
      LGNT: begin
        m_we_d    = lwe_q;
        m_addr_d  = laddr_q;
        m_wdata_d = lwdata_q;
        p_stall_d = bus.p_req;
      end
      LACK:    l_ack_d = 1'b1;
      default: ;
    endcase
  end

  // Reset gates the write strobe immediately so an in-flight loader write is aborted.
  assign bus.m_we    = m_we_d & rst_ni;
  assign bus.m_addr  = m_addr_d;
  assign bus.m_wdata = m_wdata_d;
  assign bus.p_stall = p_stall_d;
  assign bus.l_ack   = l_ack_d;
  assign bus.l_rdata = lrdata_q;
  assign bus.p_rdata = bus.m_rdata;

endmodule
